apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Shares one APB master among NUM_REQ local requesters.
- Selects a requester by round-robin and pulses the master's event trigger for one cycle.
- Holds the winner's address, write data and direction stable for the whole APB transfer.
- Returns the read data and a one-cycle done pulse to the winner. Sits between the requesters and the master's evnt_trig_i/addr_i/data_i/pwrite_i inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, APB data width.
- ADDR_WIDTH, 32, APB address width.
- TIMEOUT_CYC, 256, cycles in WAIT before timeout_o sets; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous reset, active-high.
- req_i  in  NUM_REQ  per-requester request level.
- req_write_i  in  NUM_REQ  per-requester direction (1 = write).
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data; requester i occupies slice i.
- gnt_o  out  NUM_REQ  one-hot grant, held from ISSUE through DONE.
- done_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata_o  out  DATA_WIDTH  captured PRDATA; valid while done_o is nonzero.
- m_trig_o  out  1  to master evnt_trig_i.
- m_addr_o  out  ADDR_WIDTH  to master addr_i.
- m_wdata_o  out  DATA_WIDTH  to master data_i.
- m_write_o  out  1  to master pwrite_i.
- psel_i  in  1  master PSEL.
- penable_i  in  1  master PENABLE.
- pready_i  in  1  slave PREADY.
- prdata_i  in  DATA_WIDTH  master PRDATA_o.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset: state IDLE, rr pointer 0. gnt_o, done_o, rdata_o, m_trig_o, m_addr_o, m_wdata_o, m_write_o and timeout_o are all 0. Wait counter is 0.
- Reset asserted mid-transfer: return to IDLE next edge with all outputs 0. The master is reset alongside.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, req_i != 0:
  - Pick the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - Register the winner's addr, wdata and write into m_addr_o, m_wdata_o, m_write_o.
  - Set gnt_o one-hot; go to ISSUE.
- IDLE, req_i == 0: stay in IDLE.
- ISSUE: m_trig_o = 1 for exactly this cycle; go to WAIT. Clear the wait counter.
- WAIT:
  - On psel_i & penable_i & pready_i, capture prdata_i into rdata_o and go to DONE.
  - Otherwise increment the wait counter, saturating.
  - When TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC, set timeout_o. It stays set until reset.
  - A timeout does not abort the transfer; WAIT persists until completion.
- DONE:
  - done_o = gnt_o for one cycle.
  - rr pointer = (winner+1) mod NUM_REQ.
  - Clear gnt_o; go to IDLE.
- m_addr_o, m_wdata_o and m_write_o hold their value from the grant until the next grant. They do not change during SETUP/ACCESS.
- Requesters keep req_i high until done. The arbiter samples only req_i in IDLE.
- A requester dropping req_i while granted is ignored; the transfer completes and done_o still pulses.
- Latency with zero-wait slave, req in cycle 0:
  - Cycle 1: ISSUE/trig.
  - Cycle 2: master SETUP.
  - Cycle 3: ACCESS with PREADY.
  - Cycle 4: DONE with done_o and rdata_o.
  - Cycle 5: IDLE.
- Minimum spacing between triggers is 5 cycles, so the master is always in IDLE when m_trig_o rises.
- Single requester continuously requesting: re-granted each round, no starvation by construction.
- rdata_o is captured on reads and writes alike; it is meaningful for reads only.

Decomposition:
- Package apb_arb_pkg holds:
  - state encoding localparams: IDLE = 0, ISSUE = 1, WAIT = 2, DONE = 3;
  - counter width function clog2(TIMEOUT_CYC+1).
- Sub-module apb_rr_picker: combinational. Inputs are a request vector and a pointer; outputs are a one-hot grant and the winner index.

Test Plan:
- Single read: req_i=0001, addr 0x1000, write=0, slave PREADY in first ACCESS with PRDATA=0xDEADBEEF -> m_trig_o pulse at cycle 1; done_o=0001 at cycle 4; rdata_o=0xDEADBEEF.
- Write with 3 wait states: req_i=0100, addr 0x20, wdata 0xA5A5A5A5 -> m_addr_o/m_wdata_o stable through all ACCESS cycles; done_o=0100 at cycle 7.
- Round robin: req_i=1111 held continuously -> grant order 0001, 0010, 0100, 1000, 0001; exactly one trig per transfer.
- Pointer wrap: pointer=3, req_i=0011 -> gnt_o=0001, then 0010 after done.
- Timeout: TIMEOUT_CYC=8, PREADY low for 12 cycles, then high -> timeout_o rises after 8 WAIT cycles; transfer completes; done pulses; timeout_o stays 1 until PRESET.
- Reset mid-WAIT: assert PRESET one cycle during ACCESS -> next cycle all outputs 0, state IDLE; a subsequent req_i=0010 is granted normally.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and width helpers for the APB request arbiter.
// The state enum fixes the encoding IDLE=0, ISSUE=1, WAIT=2, DONE=3.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // A zero timeout still needs a 1-bit counter so the logic stays well formed.
    function automatic int cnt_width(input int timeout_cyc);
        return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo NUM_REQ; returns a one-hot grant and the winner index.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master among NUM_REQ requesters: round-robin grant, one-cycle
// trigger, stable address/data for the transfer, and a done pulse with read data.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          m_trig_o,
    output logic [ADDR_WIDTH-1:0]         m_addr_o,
    output logic [DATA_WIDTH-1:0]         m_wdata_o,
    output logic                          m_write_o,
    input  logic                          psel_i,
    input  logic                          penable_i,
    input  logic                          pready_i,
    input  logic [DATA_WIDTH-1:0]         prdata_i,
    output logic                          timeout_o
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               xfer_done;

    assign xfer_done = psel_i & penable_i & pready_i;
    assign cnt_inc   = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req (req_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_i) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (xfer_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_trig_o = (state == ISSUE);
        done_o   = (state == DONE) ? gnt_o : '0;
    end

    // Winner's request fields are latched at grant so they stay frozen across SETUP/ACCESS.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            gnt_o     <= '0;
            win_idx   <= '0;
            rr_ptr    <= '0;
            m_addr_o  <= '0;
            m_wdata_o <= '0;
            m_write_o <= 1'b0;
            rdata_o   <= '0;
            wait_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt_o     <= pick_gnt;
                        win_idx   <= pick_idx;
                        m_addr_o  <= req_addr_i[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        m_wdata_o <= req_wdata_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                        m_write_o <= req_write_i[pick_idx];
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (xfer_done) begin
                        rdata_o <= prdata_i;
                    end else begin
                        wait_cnt <= cnt_inc;
                        if (TIMEOUT_CYC != 0 && cnt_inc == TO_VAL) begin
                            timeout_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    gnt_o  <= '0;
                    rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter; the bench plays the APB master/slave handshake.
module tb_apb_req_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic [NR-1:0]    req_i;
    logic [NR-1:0]    req_write_i;
    logic [NR*AW-1:0] req_addr_i;
    logic [NR*DW-1:0] req_wdata_i;
    logic [NR-1:0]    gnt_o;
    logic [NR-1:0]    done_o;
    logic [DW-1:0]    rdata_o;
    logic             m_trig_o;
    logic [AW-1:0]    m_addr_o;
    logic [DW-1:0]    m_wdata_o;
    logic             m_write_o;
    logic             psel_i;
    logic             penable_i;
    logic             pready_i;
    logic [DW-1:0]    prdata_i;
    logic             timeout_o;

    int compared   = 0;
    int mismatched = 0;

    apb_req_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .req_i       (req_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .m_trig_o    (m_trig_o),
        .m_addr_o    (m_addr_o),
        .m_wdata_o   (m_wdata_o),
        .m_write_o   (m_write_o),
        .psel_i      (psel_i),
        .penable_i   (penable_i),
        .pready_i    (pready_i),
        .prdata_i    (prdata_i),
        .timeout_o   (timeout_o)
    );

    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge PCLK);
    endtask

    task automatic applyStimulus(input logic [NR-1:0] req, input logic [NR-1:0] wr);
        req_i       = req;
        req_write_i = wr;
    endtask

    task automatic setSlot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr_i[i*AW +: AW]  = a;
        req_wdata_i[i*DW +: DW] = d;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"},   gnt_o,     0);
        checkOutput({tag, "_done"},  done_o,    0);
        checkOutput({tag, "_rdata"}, rdata_o,   0);
        checkOutput({tag, "_trig"},  m_trig_o,  0);
        checkOutput({tag, "_addr"},  m_addr_o,  0);
        checkOutput({tag, "_wdata"}, m_wdata_o, 0);
        checkOutput({tag, "_write"}, m_write_o, 0);
        checkOutput({tag, "_tmo"},   timeout_o, 0);
    endtask

    // Entered at the negedge of the ISSUE cycle (cycle 1); returns at the DONE cycle.
    task automatic runSlave(input int waits, input logic [DW-1:0] rd, input logic [AW-1:0] expAddr,
                            input logic [DW-1:0] expWdata, input int toCycle);
        int cyc;
        cyc = 2;
        nextCycle();
        psel_i = 1'b1; penable_i = 1'b0; pready_i = 1'b0;
        checkOutput("setup_trig_low", m_trig_o, 0);
        checkOutput("setup_tmo", timeout_o, (toCycle != 0 && cyc >= toCycle));
        for (int w = 0; w < waits; w++) begin
            nextCycle();
            cyc++;
            penable_i = 1'b1; pready_i = 1'b0;
            checkOutput("wait_addr", m_addr_o, expAddr);
            checkOutput("wait_wdata", m_wdata_o, expWdata);
            checkOutput("wait_done", done_o, 0);
            checkOutput("wait_tmo", timeout_o, (toCycle != 0 && cyc >= toCycle));
        end
        nextCycle();
        cyc++;
        penable_i = 1'b1; pready_i = 1'b1; prdata_i = rd;
        checkOutput("access_addr", m_addr_o, expAddr);
        checkOutput("access_wdata", m_wdata_o, expWdata);
        checkOutput("access_tmo", timeout_o, (toCycle != 0 && cyc >= toCycle));
        nextCycle();
        cyc++;
        psel_i = 1'b0; penable_i = 1'b0; pready_i = 1'b0; prdata_i = '0;
        checkOutput("done_tmo", timeout_o, (toCycle != 0 && cyc >= toCycle));
    endtask

    initial begin
        logic [NR-1:0] expGnt;
        PRESET = 1'b1;
        req_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0;
        psel_i = 1'b0; penable_i = 1'b0; pready_i = 1'b0; prdata_i = '0;
        nextCycle();
        nextCycle();
        checkAllZero("reset");
        PRESET = 1'b0;

        // Single zero-wait read from requester 0, which drops its request once granted
        setSlot(0, 32'h1000, 32'h0);
        applyStimulus(4'b0001, 4'b0000);
        nextCycle();
        checkOutput("rd_trig", m_trig_o, 1);
        checkOutput("rd_gnt", gnt_o, 4'b0001);
        checkOutput("rd_addr", m_addr_o, 32'h1000);
        checkOutput("rd_write", m_write_o, 0);
        applyStimulus(4'b0000, 4'b0000);
        runSlave(0, 32'hDEADBEEF, 32'h1000, 32'h0, 0);
        checkOutput("rd_done", done_o, 4'b0001);
        checkOutput("rd_rdata", rdata_o, 32'hDEADBEEF);
        nextCycle();
        checkOutput("rd_idle_done", done_o, 0);
        checkOutput("rd_idle_gnt", gnt_o, 0);
        checkOutput("rd_idle_trig", m_trig_o, 0);

        // Write with three wait states from requester 2 (pointer is now 1)
        setSlot(2, 32'h20, 32'hA5A5A5A5);
        applyStimulus(4'b0100, 4'b0100);
        nextCycle();
        checkOutput("wr_trig", m_trig_o, 1);
        checkOutput("wr_gnt", gnt_o, 4'b0100);
        checkOutput("wr_write", m_write_o, 1);
        runSlave(3, 32'h12345678, 32'h20, 32'hA5A5A5A5, 0);
        checkOutput("wr_done", done_o, 4'b0100);
        applyStimulus(4'b0000, 4'b0000);
        nextCycle();
        checkOutput("wr_idle_done", done_o, 0);

        // Pointer at 3 with requests 0 and 1: wraps to 0, then 1 next round
        setSlot(0, 32'h100, 32'h11);
        setSlot(1, 32'h104, 32'h22);
        applyStimulus(4'b0011, 4'b0011);
        nextCycle();
        checkOutput("wrap_gnt0", gnt_o, 4'b0001);
        checkOutput("wrap_addr0", m_addr_o, 32'h100);
        runSlave(0, 32'hAAAA0000, 32'h100, 32'h11, 0);
        checkOutput("wrap_done0", done_o, 4'b0001);
        nextCycle();
        checkOutput("wrap_idle_gnt", gnt_o, 0);
        nextCycle();
        checkOutput("wrap_gnt1", gnt_o, 4'b0010);
        checkOutput("wrap_addr1", m_addr_o, 32'h104);
        checkOutput("wrap_wdata1", m_wdata_o, 32'h22);
        runSlave(0, 32'hBBBB1111, 32'h104, 32'h22, 0);
        checkOutput("wrap_done1", done_o, 4'b0010);
        checkOutput("wrap_rdata1", rdata_o, 32'hBBBB1111);
        applyStimulus(4'b0000, 4'b0000);
        nextCycle();

        // Reset the pointer, then all four request continuously
        PRESET = 1'b1;
        nextCycle();
        PRESET = 1'b0;
        for (int i = 0; i < NR; i++) setSlot(i, 32'h4000 + 32'(i * 4), 32'h0);
        applyStimulus(4'b1111, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            expGnt = 4'b0001 << (k % 4);
            nextCycle();
            checkOutput("rr_trig", m_trig_o, 1);
            checkOutput("rr_gnt", gnt_o, expGnt);
            checkOutput("rr_addr", m_addr_o, 32'h4000 + 32'((k % 4) * 4));
            runSlave(0, 32'hC0DE0000 + 32'(k), 32'h4000 + 32'((k % 4) * 4), 32'h0, 0);
            checkOutput("rr_done", done_o, expGnt);
            checkOutput("rr_rdata", rdata_o, 32'hC0DE0000 + 32'(k));
            if (k == 4) applyStimulus(4'b0000, 4'b0000);
            nextCycle();
            checkOutput("rr_idle_trig", m_trig_o, 0);
        end

        // Slow slave: 12 low-PREADY ACCESS cycles; flag visible from cycle 10
        setSlot(1, 32'h300, 32'h0);
        applyStimulus(4'b0010, 4'b0000);
        nextCycle();
        checkOutput("tmo_gnt", gnt_o, 4'b0010);
        checkOutput("tmo_issue_flag", timeout_o, 0);
        runSlave(12, 32'hFEEDF00D, 32'h300, 32'h0, 10);
        checkOutput("tmo_done", done_o, 4'b0010);
        checkOutput("tmo_rdata", rdata_o, 32'hFEEDF00D);
        applyStimulus(4'b0000, 4'b0000);
        nextCycle();
        checkOutput("tmo_sticky1", timeout_o, 1);
        nextCycle();
        checkOutput("tmo_sticky2", timeout_o, 1);

        // Reset pulse during ACCESS, then the same request is granted normally
        setSlot(1, 32'h500, 32'h55);
        applyStimulus(4'b0010, 4'b0010);
        nextCycle();
        checkOutput("rst_pre_gnt", gnt_o, 4'b0010);
        nextCycle();
        psel_i = 1'b1;
        nextCycle();
        penable_i = 1'b1; pready_i = 1'b0;
        PRESET = 1'b1;
        nextCycle();
        checkAllZero("midrst");
        PRESET = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0;
        nextCycle();
        checkOutput("post_trig", m_trig_o, 1);
        checkOutput("post_gnt", gnt_o, 4'b0010);
        checkOutput("post_addr", m_addr_o, 32'h500);
        checkOutput("post_write", m_write_o, 1);
        runSlave(1, 32'h77, 32'h500, 32'h55, 0);
        checkOutput("post_done", done_o, 4'b0010);
        checkOutput("post_rdata", rdata_o, 32'h77);
        applyStimulus(4'b0000, 4'b0000);
        nextCycle();
        checkOutput("post_idle_gnt", gnt_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
